ps2_key_ctrl: RTL and testbench

Scan-code sequencer that sits directly behind the PS/2 keyboard receiver. It drains the receiver FIFO through that block's active-low read strobe and decodes Set-2 prefix sequences (E0, F0, E1 pause). It emits one make/break key event per key action over a valid/ack handshake and maintains a held-key bitmap for eight game-control keys. It also recovers from receiver FIFO overflow and from keyboard error bytes.

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/ps2_key_map.sv | 18 +
 rtl/ps2_key_ctrl.sv | 148 ++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code sequencer: Set-2 prefix/status
// bytes, the game-key map and the sequencer state encoding.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] BAT       = 8'hAA;
  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] ECHO      = 8'hEE;
  localparam logic [7:0] ERR0      = 8'h00;
  localparam logic [7:0] ERR1      = 8'hFF;

  localparam int unsigned NUM_KEYS = 8;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_UP    = 8'h75;

  // Key i occupies bits [8*i +: 8]; bit i of the mask is its required ext value.
  localparam logic [8*NUM_KEYS-1:0] KEY_CODES = {KEY_UP, KEY_ESC, KEY_ENTER, KEY_SPACE,
                                                 KEY_D, KEY_S, KEY_A, KEY_W};
  localparam logic [NUM_KEYS-1:0] KEY_EXT_MASK = 8'b1000_0000;

  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SKIP   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == BAT) || (b == ACK) || (b == ECHO);
  endfunction

  function automatic logic is_kb_error(input logic [7:0] b);
    return (b == ERR0) || (b == ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational lookup of a (scan code, extended flag) pair into a one-hot
// match over the eight tracked game keys.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic [7:0]          byte_i,
  input  logic                ext_i,
  output logic [NUM_KEYS-1:0] match_o
);

  always_comb begin
    match_o = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match_o[i] = (byte_i == KEY_CODES[i*8 +: 8]) && (ext_i == KEY_EXT_MASK[i]);
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Scan-code sequencer behind the PS/2 receiver FIFO: fetches bytes, decodes
// Set-2 prefixes, emits make/break events and tracks held game keys.
module ps2_key_ctrl
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_rdn,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  input  logic       ev_ack,
  output logic [7:0] key_down,
  output logic       err
);

  // Event handshake: an event is held on ev_code/ev_ext/ev_break while
  // ev_valid=1 and is retired at the first clock edge where ev_ack=1.
  state_e      state_q;
  logic [7:0]  byte_q;
  logic        brk_q;
  logic        ext_q;
  logic [2:0]  skip_cnt_q;
  logic        kb_rdn_q;
  logic        ev_valid_q;
  logic [7:0]  ev_code_q;
  logic        ev_ext_q;
  logic        ev_break_q;
  logic [7:0]  key_down_q;
  logic [7:0]  key_down_d;
  logic        err_q;
  logic [7:0]  match;
  logic        fetch_ok;

  ps2_key_map u_key_map (
    .byte_i  (byte_q),
    .ext_i   (ext_q),
    .match_o (match)
  );

  assign key_down_d = brk_q ? (key_down_q & ~match) : (key_down_q | match);
  // The slot is free either when empty or when it is being retired this cycle.
  assign fetch_ok   = kb_ready && (!ev_valid_q || ev_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      skip_cnt_q <= '0;
      kb_rdn_q   <= 1'b1;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_ext_q   <= 1'b0;
      ev_break_q <= 1'b0;
      key_down_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (ev_valid_q && ev_ack) ev_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (kb_overflow) begin
            err_q   <= 1'b1;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            state_q <= ST_FLUSH;
          end else if (fetch_ok) begin
            byte_q   <= kb_data;
            kb_rdn_q <= 1'b0;
            state_q  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          kb_rdn_q <= 1'b1;
          state_q  <= ST_IDLE;
          if (byte_q == PFX_BRK) begin
            brk_q <= 1'b1;
          end else if (byte_q == PFX_EXT) begin
            ext_q <= 1'b1;
          end else if (byte_q == PFX_PAUSE) begin
            skip_cnt_q <= PAUSE_TAIL;
            state_q    <= ST_SKIP;
          end else if (is_kb_error(byte_q)) begin
            err_q <= 1'b1;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
          end else if (!is_ignored(byte_q)) begin
            ev_valid_q <= 1'b1;
            ev_code_q  <= byte_q;
            ev_ext_q   <= ext_q;
            ev_break_q <= brk_q;
            key_down_q <= key_down_d;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
          end
        end
        ST_SKIP: begin
          // Each tail byte takes a strobe cycle plus a re-sample cycle.
          if (!kb_rdn_q) begin
            kb_rdn_q <= 1'b1;
            if (skip_cnt_q == '0) begin
              ev_valid_q <= 1'b1;
              ev_code_q  <= PFX_PAUSE;
              ev_ext_q   <= 1'b0;
              ev_break_q <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end else if (kb_overflow) begin
            err_q   <= 1'b1;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            state_q <= ST_FLUSH;
          end else if (fetch_ok) begin
            kb_rdn_q   <= 1'b0;
            skip_cnt_q <= skip_cnt_q - 3'd1;
          end
        end
        ST_FLUSH: begin
          if (!kb_rdn_q) begin
            kb_rdn_q <= 1'b1;
          end else if (kb_ready) begin
            kb_rdn_q <= 1'b0;
          end else begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            key_down_q <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign kb_rdn   = kb_rdn_q;
  assign ev_valid = ev_valid_q;
  assign ev_code  = ev_code_q;
  assign ev_ext   = ev_ext_q;
  assign ev_break = ev_break_q;
  assign key_down = key_down_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: receiver FIFO model, byte-stream reference model
// feeding an expected-event queue, and a monitor that checks each accepted event.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = '0;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       ev_ack = 1'b0;
  logic       kb_rdn;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] key_down;
  logic       err;

  ps2_key_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .kb_rdn      (kb_rdn),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .ev_ack      (ev_ack),
    .key_down    (key_down),
    .err         (err)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int rdn_cnt = 0;
  logic prev_low = 1'b0;
  bit rand_done = 1'b0;

  logic [7:0]  rx_q[$];
  logic [7:0]  pend_q[$];
  // {chk_kd, key_down, ext, brk, code}
  logic [18:0] exp_q[$];

  // ---------------- reference model state ----------------
  logic [7:0] key_code [0:7] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h75};
  bit         key_ext  [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] pool [0:15] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h75,
                              8'h14, 8'h11, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'hAA, 8'hE1};
  logic [7:0] m_kd = '0;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_err = 1'b0;
  int         pause_left = 0;
  bit         kd_chk_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic push_event(input logic [7:0] code, input bit ext, input bit brk);
    exp_q.push_back({kd_chk_en, m_kd, ext, brk, code});
  endtask

  // Applies one consumed byte to the Set-2 interpretation rules.
  task automatic model_byte(input logic [7:0] b);
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) push_event(8'hE1, 1'b0, 1'b0);
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hE1) begin
      pause_left = 7;
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1'b1;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE) begin
      m_err = m_err;
    end else begin
      for (int k = 0; k < 8; k++)
        if (key_code[k] == b && key_ext[k] == m_ext) m_kd[k] = !m_brk;
      push_event(b, m_ext, m_brk);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  // ---------------- receiver FIFO model (depth 8) ----------------
  initial begin
    bit rd;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      rd = (kb_rdn === 1'b0);
      @(posedge clk);
      #1;
      if (rst) begin
        rx_q.delete();
        pend_q.delete();
        kb_overflow = 1'b0;
      end else begin
        if (rd && rx_q.size() > 0) begin
          void'(rx_q.pop_front());
          kb_overflow = 1'b0;
        end
        if (pend_q.size() > 0) begin
          b = pend_q.pop_front();
          if (rx_q.size() >= 8) kb_overflow = 1'b1;
          else rx_q.push_back(b);
        end
      end
      kb_ready = (rx_q.size() > 0);
      kb_data  = kb_ready ? rx_q[0] : 8'h00;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_low = 1'b0;
      end else begin
        if (kb_rdn === 1'b0) begin
          rdn_cnt++;
          check("rdn_single_cycle", {31'd0, prev_low}, 32'd0);
        end
        prev_low = (kb_rdn === 1'b0);
        if (ev_valid && ev_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got code %02h ext %0d brk %0d required none",
                     ev_code, ev_ext, ev_break);
          end else begin
            e = exp_q.pop_front();
            check("ev_code", {24'd0, ev_code}, {24'd0, e[7:0]});
            check("ev_break", {31'd0, ev_break}, {31'd0, e[8]});
            check("ev_ext", {31'd0, ev_ext}, {31'd0, e[9]});
            if (e[18]) check("ev_key_down", {24'd0, key_down}, {24'd0, e[17:10]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit use_model);
    int n = 0;
    while (rx_q.size() + pend_q.size() >= 6 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 2000) fail_now("send_space");
    pend_q.push_back(b);
    if (use_model) model_byte(b);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (pend_q.size() == 0) && (rx_q.size() == 0) && (exp_q.size() == 0) &&
             !ev_valid && (kb_rdn === 1'b1);
    end
    if (!done) fail_now(name);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_ev_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (ev_valid === 1'b1);
    end
    if (!seen) fail_now(name);
    @(posedge clk);
    #2;
  endtask

  task automatic end_checks(input string tag);
    @(negedge clk);
    check({tag, "_key_down"}, {24'd0, key_down}, {24'd0, m_kd});
    check({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_kb_rdn"}, {31'd0, kb_rdn}, 32'd1);
    check({tag, "_ev_valid"}, {31'd0, ev_valid}, 32'd0);
    check({tag, "_ev_code"}, {24'd0, ev_code}, 32'd0);
    check({tag, "_ev_ext"}, {31'd0, ev_ext}, 32'd0);
    check({tag, "_ev_break"}, {31'd0, ev_break}, 32'd0);
    check({tag, "_key_down"}, {24'd0, key_down}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int p0;
    bit hit;
    logic [7:0] ovf_bytes [0:8] = '{8'h1D, 8'h1B, 8'hF0, 8'h1D, 8'h23, 8'h5A, 8'h76, 8'hF0, 8'h29};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    ev_ack = 1'b1;

    // Press and release W
    p0 = rdn_cnt;
    send_byte(8'h1D, 1); send_byte(8'hF0, 1); send_byte(8'h1D, 1);
    wait_idle("w_idle");
    check("w_rdn_pulses", rdn_cnt - p0, 32'd3);
    end_checks("w");

    // Extended UP in both prefix orders, then plain 75
    send_byte(8'hE0, 1); send_byte(8'h75, 1);
    send_byte(8'hF0, 1); send_byte(8'hE0, 1); send_byte(8'h75, 1);
    send_byte(8'hE0, 1); send_byte(8'h75, 1);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
    send_byte(8'h75, 1);
    wait_idle("up_idle");
    end_checks("up");
    send_byte(8'hF0, 1); send_byte(8'h75, 1);
    wait_idle("up2_idle");

    // Pause sequence
    send_byte(8'h1C, 1);
    p0 = rdn_cnt;
    foreach (pool[i]) if (i < 0) send_byte(8'h00, 0);
    send_byte(8'hE1, 1); send_byte(8'h14, 1); send_byte(8'h77, 1); send_byte(8'hE1, 1);
    send_byte(8'hF0, 1); send_byte(8'h14, 1); send_byte(8'hF0, 1); send_byte(8'h77, 1);
    wait_idle("pause_idle");
    check("pause_rdn_pulses", rdn_cnt - p0 - 1, 32'd8);
    end_checks("pause");

    // Backpressure
    ev_ack = 1'b0;
    send_byte(8'h1B, 1); send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    ev_ack = 1'b1;
    wait_idle("bp_prep");
    ev_ack = 1'b0;
    send_byte(8'h1C, 1); send_byte(8'h1B, 1);
    wait_ev_valid("bp_first");
    p0 = rdn_cnt;
    repeat (10) @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_no_fetch", rdn_cnt - p0, 32'd0);
    check("bp_hold_valid", {31'd0, ev_valid}, 32'd1);
    check("bp_hold_code", {24'd0, ev_code}, 32'h1C);
    @(posedge clk);
    #2;
    ev_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("bp_next_valid", {31'd0, ev_valid}, 32'd1);
    check("bp_next_code", {24'd0, ev_code}, 32'h1B);
    wait_idle("bp_idle");
    end_checks("bp");

    // Randomized byte stream with random acknowledge
    fork
      begin
        for (int i = 0; i < 80; i++) send_byte(pool[$urandom_range(0, 15)], 1);
        while (pause_left > 0) send_byte(8'h14, 1);
        send_byte(8'h14, 1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2;
          ev_ack = ($urandom_range(0, 1) == 1);
        end
      end
    join
    ev_ack = 1'b1;
    wait_idle("rand_idle");
    end_checks("rand");

    // Keyboard error byte after E0
    send_byte(8'hE0, 1); send_byte(8'hFF, 1); send_byte(8'h23, 1);
    wait_idle("err_idle");
    end_checks("errbyte");

    // Reset while a byte is in DECODE
    send_byte(8'h29, 1);
    wait_idle("rst_prep");
    send_byte(8'h1C, 0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = (kb_rdn === 1'b0);
    end
    if (!hit) fail_now("rst_decode");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_kd = '0; m_brk = 1'b0; m_ext = 1'b0; m_err = 1'b0; pause_left = 0;
    repeat (4) @(posedge clk);
    #2;
    end_checks("postrst");

    // Overflow recovery with a dangling F0 in the FIFO
    ev_ack = 1'b0;
    kd_chk_en = 1'b0;
    send_byte(8'h1C, 1);
    wait_ev_valid("ovf_first");
    kd_chk_en = 1'b1;
    foreach (ovf_bytes[i]) pend_q.push_back(ovf_bytes[i]);
    m_kd = '0; m_brk = 1'b0; m_ext = 1'b0; m_err = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (pend_q.size() == 0) && (rx_q.size() == 0);
    end
    if (!hit) fail_now("ovf_drain");
    repeat (4) @(posedge clk);
    #2;
    @(negedge clk);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_key_down", {24'd0, key_down}, 32'd0);
    check("ovf_ev_hold", {31'd0, ev_valid}, 32'd1);
    @(posedge clk);
    #2;
    ev_ack = 1'b1;
    wait_idle("ovf_ack");
    send_byte(8'h29, 1);
    wait_idle("ovf_after");
    end_checks("ovf");

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
